ram_rd_stream: RTL and testbench
================================

# ram_rd_stream

Single-clock read-side sequencer for the inferred block RAMs. It accepts (start address, length) commands, drives the RAM read address, and absorbs the RAM's one-cycle registered read latency. Data leaves through a 2-entry skid buffer as a valid/ready stream with end-of-burst marking. It sits directly downstream of the RAM read port, on the RAM's read clock, and feeds packet/stream consumers.

## Interface
- DATAWIDTH, 18, RAM word width; must match the RAM.
- ADDRWIDTH, 5, RAM address width; depth = 2^ADDRWIDTH.
- LENWIDTH, ADDRWIDTH+1, width of the burst length field.

- clk  in  1  sole clock; also drives the RAM read clock.
- reset  in  1  asynchronous, active-high; clears all state.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a rising edge.
- cmd_addr  in  ADDRWIDTH  first word address.
- cmd_len  in  LENWIDTH  number of words to read; 0 allowed.
- ram_rd_addr  out  ADDRWIDTH  to RAM read address; RAM samples it every edge.
- ram_rd_data  in  DATAWIDTH  from RAM; holds the word for the address sampled at the previous edge.
- out_valid  out  1  out_data/out_last valid.
- out_ready  in  1  consumer accepts when out_valid & out_ready at an edge.
- out_data  out  DATAWIDTH  head-of-buffer word.
- out_last  out  1  head word is the final word of its command.
- busy  out  1  command reads outstanding, in flight, or buffered.

## Operation
- State registers:
  - rd_ptr (ADDRWIDTH)
  - remaining (LENWIDTH)
  - inflight (1 bit) plus inflight_last
  - 2-entry buffer: data and last per entry, occupancy occ 0..2
- ram_rd_addr = rd_ptr, combinational from the register.
- Command accept (cmd_valid & cmd_ready):
  - rd_ptr <= cmd_addr, remaining <= cmd_len.
  - cmd_ready = (remaining == 0), a registered condition.
  - cmd_len = 0 is accepted and produces no output and no reads.
- Issue (internal, combinational): issue = (remaining != 0) & (occ + inflight - pop <= 1), where pop = out_valid & out_ready.
- On an issue edge:
  - rd_ptr <= rd_ptr + 1, wrapping modulo 2^ADDRWIDTH.
  - remaining <= remaining - 1.
  - inflight <= 1, inflight_last <= (remaining == 1).
  - With no issue, inflight <= 0.
- Edge with inflight = 1: ram_rd_data and inflight_last are pushed into the buffer. Push and pop in the same edge are both honored.
- Buffer ordering is FIFO. out_valid = (occ != 0); out_data/out_last come from the head entry.
- The buffer never overflows because issue reserves space. A bench assertion checks that occ never exceeds 2.
- busy = (remaining != 0) | inflight | (occ != 0).
- A new command may be accepted while the previous burst's words are still inflight or buffered. Bursts never interleave; last flags travel with their words.
- cmd_len > 2^ADDRWIDTH: reads continue wrapping through the RAM; no error is raised.
- Combinational path out_ready -> issue -> rd_ptr update is intentional; it is required for full throughput.

## Timing
- Reset values:
  - cmd_ready = 1, out_valid = 0, out_last = 0, out_data = 0, ram_rd_addr = 0, busy = 0.
  - remaining = 0, inflight = 0, occ = 0.
- Reset asserted mid-burst discards all buffered and inflight words. The first cycle after release behaves as post-reset idle.
- Latency: command accepted at edge E0 → ram_rd_addr = cmd_addr during cycle E0..E1, issued at E1 → out_valid high after E2.
- Throughput:
  - With out_ready held high, one word per cycle within a burst.
  - One idle cycle between back-to-back commands, because cmd_ready rises only after the last issue.
- Backpressure: with out_ready low, at most 2 words are buffered. Issue stops while occ + inflight = 2.
- Once out_ready rises, streaming resumes with no lost or duplicated words.
- out_data/out_last are stable while out_valid & !out_ready.

## Test plan
- RAM preloaded with mem[i] = i+0x100; cmd (addr 3, len 4), out_ready=1 → out_data 0x103,0x104,0x105,0x106 on consecutive cycles starting 2 cycles after accept; out_last only on 0x106; busy falls the cycle after the last pop.
- cmd (addr 30, len 4) with ADDRWIDTH=5 → addresses 30,31,0,1; data 0x11E,0x11F,0x100,0x101.
- cmd (addr 0, len 8), out_ready toggling 1,0,0,1,0,1… random → exactly 8 words in order; occ ≤ 2 always; data held stable during stalls.
- Back-to-back cmds (0,len 2) then (10,len 1), out_ready=1 → 0x100,0x101(last),0x10A(last); second cmd accepted exactly one cycle after first cmd_ready rise.
- cmd len 0 → no out_valid; cmd_ready returns 1 the next cycle; busy stays 0.
- Assert reset while 2 words are buffered and 3 remain → all outputs at reset values immediately; a subsequent cmd (5, len 1) yields only 0x105.

Source files
------------

// File: rtl/ram_rd_stream_if.sv
// Bundle of the command, RAM read-port and output-stream signals of ram_rd_stream.
// The master modport is the sequencer side; slave is the surrounding RAM/producer/consumer.
interface ram_rd_stream_if #(
  parameter int DATAWIDTH = 18,
  parameter int ADDRWIDTH = 5,
  parameter int LENWIDTH  = ADDRWIDTH + 1
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [ADDRWIDTH-1:0] cmd_addr;
  logic [LENWIDTH-1:0]  cmd_len;
  logic [ADDRWIDTH-1:0] ram_rd_addr;
  logic [DATAWIDTH-1:0] ram_rd_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATAWIDTH-1:0] out_data;
  logic                 out_last;
  logic                 busy;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, ram_rd_data, out_ready,
    output cmd_ready, ram_rd_addr, out_valid, out_data, out_last, busy
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, ram_rd_data, out_ready,
    input  cmd_ready, ram_rd_addr, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/ram_rd_stream.sv
// Read-side sequencer for an inferred block RAM: walks (addr, len) commands over the RAM
// read port and streams the one-cycle-late read data through a 2-entry skid buffer.
module ram_rd_stream #(
  parameter int DATAWIDTH = 18,
  parameter int ADDRWIDTH = 5,
  parameter int LENWIDTH  = ADDRWIDTH + 1
) (
  input  logic            clk,
  input  logic            reset,
  ram_rd_stream_if.master bus
);

  localparam logic [ADDRWIDTH-1:0] ADDR_ZERO = {ADDRWIDTH{1'b0}};
  localparam logic [ADDRWIDTH-1:0] ADDR_ONE  = {{(ADDRWIDTH-1){1'b0}}, 1'b1};
  localparam logic [LENWIDTH-1:0]  LEN_ZERO  = {LENWIDTH{1'b0}};
  localparam logic [LENWIDTH-1:0]  LEN_ONE   = {{(LENWIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATAWIDTH-1:0] DATA_ZERO = {DATAWIDTH{1'b0}};

  logic [ADDRWIDTH-1:0] rd_ptr_r,      rd_ptr_nx_s;
  logic [LENWIDTH-1:0]  remaining_r,   remaining_nx_s;
  logic                 inflight_r,    inflight_nx_s;
  logic                 inflight_last_r, inflight_last_nx_s;
  logic [DATAWIDTH-1:0] buf_data_r [2];
  logic [DATAWIDTH-1:0] buf_data_nx_s [2];
  logic [1:0]           buf_last_r,    buf_last_nx_s;
  logic [1:0]           occ_r,         occ_nx_s;
  logic                 cmd_ready_r,   cmd_ready_nx_s;
  logic                 out_valid_r,   out_valid_nx_s;
  logic                 busy_r,        busy_nx_s;

  logic                 cmd_accept_s;
  logic                 pop_s;
  logic                 push_s;
  logic                 issue_s;
  logic [2:0]           level_s;

  // Handshake decode; issue only when the word it launches is guaranteed a buffer slot.
  always_comb begin
    cmd_accept_s = bus.cmd_valid & cmd_ready_r;
    pop_s        = out_valid_r & bus.out_ready;
    push_s       = inflight_r;
    level_s      = {1'b0, occ_r} + {2'b00, inflight_r};
    issue_s      = (remaining_r != LEN_ZERO) && (level_s <= (3'd1 + {2'b00, pop_s}));
  end

  // Read pointer, remaining count and in-flight tracking.
  always_comb begin
    rd_ptr_nx_s        = rd_ptr_r;
    remaining_nx_s     = remaining_r;
    inflight_nx_s      = issue_s;
    inflight_last_nx_s = inflight_last_r;
    if (cmd_accept_s) begin
      rd_ptr_nx_s    = bus.cmd_addr;
      remaining_nx_s = bus.cmd_len;
    end else if (issue_s) begin
      rd_ptr_nx_s        = rd_ptr_r + ADDR_ONE;
      remaining_nx_s     = remaining_r - LEN_ONE;
      inflight_last_nx_s = (remaining_r == LEN_ONE);
    end else begin
      inflight_last_nx_s = inflight_last_r;
    end
  end

  // Skid buffer: entry 0 is always the head, so a pop shifts entry 1 down.
  always_comb begin
    buf_data_nx_s = buf_data_r;
    buf_last_nx_s = buf_last_r;
    occ_nx_s      = occ_r;
    case ({push_s, pop_s})
      2'b10: begin
        buf_data_nx_s[occ_r[0]] = bus.ram_rd_data;
        buf_last_nx_s[occ_r[0]] = inflight_last_r;
        occ_nx_s                = occ_r + 2'd1;
      end
      2'b01: begin
        buf_data_nx_s[0] = buf_data_r[1];
        buf_last_nx_s[0] = buf_last_r[1];
        occ_nx_s         = occ_r - 2'd1;
      end
      2'b11: begin
        if (occ_r == 2'd2) begin
          buf_data_nx_s[0] = buf_data_r[1];
          buf_last_nx_s[0] = buf_last_r[1];
          buf_data_nx_s[1] = bus.ram_rd_data;
          buf_last_nx_s[1] = inflight_last_r;
        end else begin
          buf_data_nx_s[0] = bus.ram_rd_data;
          buf_last_nx_s[0] = inflight_last_r;
        end
      end
      default: begin
        occ_nx_s = occ_r;
      end
    endcase
  end

  // Status flags are computed from next state so the outputs come straight from flops.
  always_comb begin
    cmd_ready_nx_s = (remaining_nx_s == LEN_ZERO);
    out_valid_nx_s = (occ_nx_s != 2'd0);
    busy_nx_s      = (remaining_nx_s != LEN_ZERO) | inflight_nx_s | (occ_nx_s != 2'd0);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_r        <= ADDR_ZERO;
      remaining_r     <= LEN_ZERO;
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
      buf_data_r[0]   <= DATA_ZERO;
      buf_data_r[1]   <= DATA_ZERO;
      buf_last_r      <= 2'b00;
      occ_r           <= 2'd0;
      cmd_ready_r     <= 1'b1;
      out_valid_r     <= 1'b0;
      busy_r          <= 1'b0;
    end else begin
      rd_ptr_r        <= rd_ptr_nx_s;
      remaining_r     <= remaining_nx_s;
      inflight_r      <= inflight_nx_s;
      inflight_last_r <= inflight_last_nx_s;
      buf_data_r[0]   <= buf_data_nx_s[0];
      buf_data_r[1]   <= buf_data_nx_s[1];
      buf_last_r      <= buf_last_nx_s;
      occ_r           <= occ_nx_s;
      cmd_ready_r     <= cmd_ready_nx_s;
      out_valid_r     <= out_valid_nx_s;
      busy_r          <= busy_nx_s;
    end
  end

  assign bus.ram_rd_addr = rd_ptr_r;
  assign bus.cmd_ready   = cmd_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_data    = buf_data_r[0];
  assign bus.out_last    = buf_last_r[0];
  assign bus.busy        = busy_r;

endmodule

// File: tb/tb_ram_rd_stream.sv
// Directed bench for ram_rd_stream with a registered-read RAM model (mem[i] = 0x100 + i).
module tb_ram_rd_stream;
  localparam int DW = 18;
  localparam int AW = 5;
  localparam int LW = 6;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  logic [DW-1:0] mem [32];
  logic [DW:0]   got_q [$];

  ram_rd_stream_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .LENWIDTH(LW)) bus ();

  ram_rd_stream #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .LENWIDTH(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Registered-read RAM.
  always @(posedge clk) bus.ram_rd_data <= mem[bus.ram_rd_addr];

  // Collect every accepted output word as {last, data}.
  always @(posedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) got_q.push_back({bus.out_last, bus.out_data});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [AW-1:0] a, input logic [LW-1:0] n);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_len   = n;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_last"},  32'(bus.out_last),  32'd0);
    check({tag, "_out_data"},  32'(bus.out_data),  32'd0);
    check({tag, "_rd_addr"},   32'(bus.ram_rd_addr), 32'd0);
    check({tag, "_busy"},      32'(bus.busy),      32'd0);
  endtask

  // Full-rate burst: address walk, 2-cycle latency, data order, last flag, busy drop.
  task automatic burst_full(input logic [AW-1:0] a, input int n);
    logic [AW-1:0] ea;
    bus.out_ready = 1'b1;
    send_cmd(a, LW'(n));
    check("burst_cmd_ready_low", 32'(bus.cmd_ready), 32'd0);
    check("burst_busy_high",     32'(bus.busy),      32'd1);
    for (int k = 0; k <= n + 1; k++) begin
      if (k > 0) tick();
      if (k < n) begin
        ea = a + AW'(k);
        check("burst_rd_addr", 32'(bus.ram_rd_addr), 32'(ea));
      end
      if (k >= 2) begin
        ea = a + AW'(k - 2);
        check("burst_valid", 32'(bus.out_valid), 32'd1);
        check("burst_data",  32'(bus.out_data),  32'h100 + 32'(ea));
        check("burst_last",  32'(bus.out_last),  32'(k == n + 1));
      end else begin
        check("burst_valid_early", 32'(bus.out_valid), 32'd0);
      end
    end
    tick();
    check("burst_valid_end", 32'(bus.out_valid), 32'd0);
    check("burst_busy_end",  32'(bus.busy),      32'd0);
    check("burst_ready_end", 32'(bus.cmd_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] pat;
    logic        prev_stall;
    logic [DW:0] prev_word;
    int          rise_at;

    for (int i = 0; i < 32; i++) mem[i] = DW'(32'h100 + i);
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check_reset_values("rst");
    reset = 1'b0;
    tick();

    // Plain burst and wrap-around burst.
    burst_full(5'd3, 4);
    burst_full(5'd30, 4);

    // Random-ish backpressure: order, stability during stalls, occupancy bound.
    got_q.delete();
    pat        = 32'hD6B3_5A29;
    prev_stall = 1'b0;
    prev_word  = '0;
    bus.out_ready = pat[0];
    send_cmd(5'd0, 6'd8);
    for (int c = 1; c < 80; c++) begin
      if (prev_stall) begin
        check("stall_valid", 32'(bus.out_valid), 32'd1);
        check("stall_word",  32'({bus.out_last, bus.out_data}), 32'(prev_word));
      end
      check("occ_le2", 32'(dut.occ_r <= 2'd2), 32'd1);
      bus.out_ready = pat[c % 32];
      prev_stall    = bus.out_valid & ~bus.out_ready;
      prev_word     = {bus.out_last, bus.out_data};
      tick();
    end
    check("stall_count", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < got_q.size()) check("stall_order", 32'(got_q[i]), {13'd0, (i == 7), 18'h100 + 18'(i)});
    end
    check("stall_busy_end", 32'(bus.busy), 32'd0);

    // Back-to-back commands: second one waits for cmd_ready, accepted one cycle after it rises.
    got_q.delete();
    bus.out_ready = 1'b1;
    send_cmd(5'd0, 6'd2);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 5'd10;
    bus.cmd_len   = 6'd1;
    rise_at = -1;
    for (int c = 0; c < 10 && rise_at < 0; c++) begin
      if (bus.cmd_ready) rise_at = c;
      else tick();
    end
    check("b2b_rise_cycle", 32'(rise_at), 32'd2);
    tick();
    bus.cmd_valid = 1'b0;
    check("b2b_accepted_ready", 32'(bus.cmd_ready),   32'd0);
    check("b2b_accepted_addr",  32'(bus.ram_rd_addr), 32'd10);
    for (int c = 0; c < 6; c++) tick();
    check("b2b_count", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) begin
      check("b2b_w0", 32'(got_q[0]), {13'd0, 1'b0, 18'h100});
      check("b2b_w1", 32'(got_q[1]), {13'd0, 1'b1, 18'h101});
      check("b2b_w2", 32'(got_q[2]), {13'd0, 1'b1, 18'h10A});
    end
    check("b2b_busy_end", 32'(bus.busy), 32'd0);

    // Zero-length command.
    got_q.delete();
    send_cmd(5'd7, 6'd0);
    check("len0_ready", 32'(bus.cmd_ready), 32'd1);
    check("len0_busy",  32'(bus.busy),      32'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("len0_valid", 32'(bus.out_valid), 32'd0);
      check("len0_busy2", 32'(bus.busy),      32'd0);
    end
    check("len0_count", 32'(got_q.size()), 32'd0);

    // Reset while two words are buffered and three remain.
    bus.out_ready = 1'b0;
    send_cmd(5'd0, 6'd5);
    tick();
    tick();
    tick();
    check("mid_valid", 32'(bus.out_valid), 32'd1);
    check("mid_data",  32'(bus.out_data),  32'h100);
    check("mid_occ",   32'(dut.occ_r),     32'd2);
    check("mid_rem",   32'(dut.remaining_r), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("midrst");
    tick();
    reset = 1'b0;
    got_q.delete();
    bus.out_ready = 1'b1;
    send_cmd(5'd5, 6'd1);
    for (int c = 0; c < 6; c++) tick();
    check("post_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() == 1) check("post_word", 32'(got_q[0]), {13'd0, 1'b1, 18'h105});
    check("post_busy", 32'(bus.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
